// File: rtl/des_pkg.sv
// Shared DES constants: PC-1/PC-2 bit maps, per-round shift schedule,
// key-schedule state encoding and a C/D half rotate helper.
package des_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // PC-1: entry i gives the key bit (1 = MSB) placed at C||D position i+1.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: entry i gives the C||D bit (1 = MSB) placed at subkey position i+1.
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left-rotate amount applied before each encrypt round (index 0 = round 1).
    localparam int SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Rotate one 28-bit key half by 1 or 2 places, either direction, in one step.
    function automatic logic [1:28] rot28(input logic [1:28] x,
                                          input logic right,
                                          input logic two);
        logic [1:28] y;
        case ({right, two})
            2'b00:   y = {x[2:28], x[1]};
            2'b01:   y = {x[3:28], x[1:2]};
            2'b10:   y = {x[28], x[1:27]};
            default: y = {x[27:28], x[1:26]};
        endcase
        return y;
    endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression: selects 48 of the 56 C||D bits to form a round subkey.
module des_pc2
    import des_pkg::*;
(
    input  logic [1:56] cd,
    output logic [1:48] k
);

    for (genvar g = 0; g < 48; g++) begin : g_pc2
        assign k[g+1] = cd[PC2[g]];
    end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES subkey generator: one 48-bit subkey per handshake, in
// encrypt (K1..K16) or decrypt (K16..K1) order.
//
// state | meaning
// IDLE  | waiting for start; busy and subkey_valid low
// RUN   | presenting subkey for round `round`; advances on each transfer
module des_key_schedule
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [1:64] key,
    output logic        busy,
    output logic [1:48] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round,
    output logic        done
);

    state_t      state, state_nxt;
    logic [1:28] c_q, d_q;
    logic [1:28] c_nxt, d_nxt;
    logic        dec_q;
    logic        load, adv, fin;
    logic [3:0]  sh_idx;
    logic        two;
    logic [1:56] pc1_key;
    logic [1:48] pc2_out;

    // Parity bits 8,16,..,64 never appear in PC-1, so they drop out here.
    for (genvar g = 0; g < 56; g++) begin : g_pc1
        assign pc1_key[g+1] = key[PC1[g]];
    end

    // Subkey is formed from the C/D value about to be registered, so the
    // subkey register and C/D always agree.
    des_pc2 u_pc2 (
        .cd ({c_nxt, d_nxt}),
        .k  (pc2_out)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, handshake decode and C/D rotation selection.
    always_comb begin
        state_nxt = state;
        c_nxt     = c_q;
        d_nxt     = d_q;
        load      = 1'b0;
        adv       = 1'b0;
        fin       = 1'b0;
        sh_idx    = 4'd0;
        two       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                    // Decrypt starts from C0/D0, which already yield K16.
                    if (decrypt) begin
                        c_nxt = pc1_key[1:28];
                        d_nxt = pc1_key[29:56];
                    end else begin
                        c_nxt = rot28(pc1_key[1:28], 1'b0, 1'b0);
                        d_nxt = rot28(pc1_key[29:56], 1'b0, 1'b0);
                    end
                end
            end
            RUN: begin
                if (subkey_valid && subkey_ready) begin
                    if (round == 4'd15) begin
                        fin       = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        adv    = 1'b1;
                        // Decrypt undoes the encrypt shifts in reverse order.
                        sh_idx = dec_q ? (4'd15 - round) : (round + 4'd1);
                        two    = (SHIFT[sh_idx] == 2);
                        c_nxt  = rot28(c_q, dec_q, two);
                        d_nxt  = rot28(d_q, dec_q, two);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered datapath and outputs; everything holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q          <= '0;
            d_q          <= '0;
            dec_q        <= 1'b0;
            subkey       <= '0;
            round        <= '0;
            busy         <= 1'b0;
            subkey_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= fin;
            if (load) begin
                dec_q        <= decrypt;
                c_q          <= c_nxt;
                d_q          <= d_nxt;
                subkey       <= pc2_out;
                round        <= 4'd0;
                busy         <= 1'b1;
                subkey_valid <= 1'b1;
            end else if (adv) begin
                c_q    <= c_nxt;
                d_q    <= d_nxt;
                subkey <= pc2_out;
                round  <= round + 4'd1;
            end else if (fin) begin
                busy         <= 1'b0;
                subkey_valid <= 1'b0;
            end
        end
    end

endmodule
